// File: rtl/spi_shader_loader_pkg.sv
// Shared definitions for the SPI shader loader: command op codes, FSM states
// and shader memory geometry.
package spi_shader_loader_pkg;

  localparam int SHADER_MEM_DEPTH = 16;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_READ  = 2'b01,
    OP_CTRL  = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_WRITE  = 3'd2,
    ST_READ   = 3'd3,
    ST_CTRL   = 3'd4,
    ST_IGNORE = 3'd5
  } state_e;

endpackage

// File: rtl/spi_shader_loader_sync.sv
// Multi-flop synchronizer for an asynchronous level, with single-clk rise and
// fall pulses derived by comparing the synchronized level to its previous value.
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  // Reset to 0 so a chip select already low when reset lifts never looks like
  // a fresh falling edge; a real rise must come first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign dout = sync_q[SYNC_STAGES-1];
  assign rise = dout & ~prev_q;
  assign fall = ~dout & prev_q;

endmodule

// File: rtl/spi_shader_loader.sv
// SPI mode-0 slave that loads/reads the 16x8 shader memory and a control register.
//   state     | meaning
//   ST_IDLE   | cs_n high (or not yet re-armed after reset), no activity
//   ST_CMD    | shifting in the command byte
//   ST_WRITE  | each data byte written to shader memory, address auto-increments
//   ST_READ   | memory bytes shifted out on miso, address auto-increments
//   ST_CTRL   | next data byte lands in ctrl_reg
//   ST_IGNORE | consume bytes until cs_n rises
module spi_shader_loader
  import spi_shader_loader_pkg::*;
#(
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_sclk,
  input  logic              spi_mosi,
  input  logic              spi_cs_n,
  output logic              spi_miso,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [7:0]        ctrl_reg,
  output logic              busy
);

  logic sclk_level_unused, sclk_rise, sclk_fall;
  logic cs_s, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic mosi_s;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .din(spi_sclk),
    .dout(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .din(spi_cs_n),
    .dout(cs_s), .rise(cs_rise), .fall(cs_fall)
  );

  assign mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
  assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];

  state_e            state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] rx_q, rx_d, tx_q, tx_d;
  logic [ADDR_W-1:0] addr_q, addr_d, waddr_q, waddr_d, raddr_q, raddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [7:0]        ctrl_q, ctrl_d;
  logic              we_q, we_d, busy_q, busy_d;
  logic [1:0]        ld_pipe_q, ld_pipe_d;
  logic [DATA_W-1:0] rx_byte;
  logic              byte_done;

  assign rx_byte   = {rx_q[DATA_W-2:0], mosi_s};
  assign byte_done = (state_q != ST_IDLE) && sclk_rise && (bit_cnt_q == 3'd7);

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    addr_d    = addr_q;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    raddr_d   = raddr_q;
    ctrl_d    = ctrl_q;
    we_d      = 1'b0;
    busy_d    = ~cs_s;
    // Read data is valid two clks after the byte completes (raddr flop + memory latency).
    ld_pipe_d = {ld_pipe_q[0], 1'b0};

    if (cs_rise) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      rx_d      = '0;
      tx_d      = '0;
      ld_pipe_d = '0;
    end else if (state_q == ST_IDLE) begin
      if (cs_fall) begin
        state_d   = ST_CMD;
        bit_cnt_d = '0;
        tx_d      = '0;
      end
    end else begin
      if (sclk_rise) begin
        rx_d      = rx_byte;
        bit_cnt_d = bit_cnt_q + 3'd1;
      end
      // The fall that ends a byte must not shift, or the freshly loaded MSB is lost.
      if (sclk_fall && (state_q == ST_READ) && (bit_cnt_q != 3'd0))
        tx_d = {tx_q[DATA_W-2:0], 1'b0};
      if (ld_pipe_q[1])
        tx_d = mem_rdata;

      if (byte_done) begin
        case (state_q)
          ST_CMD: begin
            addr_d = rx_byte[ADDR_W-1:0];
            case (op_e'(rx_byte[7:6]))
              OP_WRITE: state_d = ST_WRITE;
              OP_READ: begin
                state_d      = ST_READ;
                raddr_d      = rx_byte[ADDR_W-1:0];
                ld_pipe_d[0] = 1'b1;
              end
              OP_CTRL: state_d = ST_CTRL;
              default: state_d = ST_IGNORE;
            endcase
          end
          ST_WRITE: begin
            we_d    = 1'b1;
            waddr_d = addr_q;
            wdata_d = rx_byte;
            addr_d  = addr_q + 1'b1;
          end
          ST_READ: begin
            addr_d       = addr_q + 1'b1;
            raddr_d      = addr_q + 1'b1;
            ld_pipe_d[0] = 1'b1;
          end
          ST_CTRL: begin
            ctrl_d  = rx_byte;
            state_d = ST_IGNORE;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      addr_q      <= '0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      raddr_q     <= '0;
      ctrl_q      <= '0;
      we_q        <= 1'b0;
      busy_q      <= 1'b0;
      ld_pipe_q   <= '0;
      mosi_sync_q <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      addr_q      <= addr_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      raddr_q     <= raddr_d;
      ctrl_q      <= ctrl_d;
      we_q        <= we_d;
      busy_q      <= busy_d;
      ld_pipe_q   <= ld_pipe_d;
      mosi_sync_q <= mosi_sync_d;
    end
  end

  assign spi_miso  = (state_q == ST_READ) ? tx_q[DATA_W-1] : 1'b0;
  assign mem_we    = we_q;
  assign mem_waddr = waddr_q;
  assign mem_wdata = wdata_q;
  assign mem_raddr = raddr_q;
  assign ctrl_reg  = ctrl_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_spi_shader_loader.sv
// Bench for spi_shader_loader: a host-side SPI driver, an emulated shader
// memory, and a frame-level reference model of the command protocol.
module tb_spi_shader_loader;

  logic       clk = 1'b0;
  logic       rst_n, spi_sclk, spi_mosi, spi_cs_n, spi_miso, mem_we, busy;
  logic [3:0] mem_waddr, mem_raddr;
  logic [7:0] mem_wdata, mem_rdata, ctrl_reg;

  always #5 clk = ~clk;

  spi_shader_loader dut (
    .clk(clk), .rst_n(rst_n), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
    .spi_cs_n(spi_cs_n), .spi_miso(spi_miso), .mem_we(mem_we),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_raddr(mem_raddr),
    .mem_rdata(mem_rdata), .ctrl_reg(ctrl_reg), .busy(busy)
  );

  // Emulated shader memory: synchronous read, one clk latency.
  logic [7:0] mem_arr [16];
  always @(posedge clk) begin
    if (mem_we) mem_arr[mem_waddr] <= mem_wdata;
    mem_rdata <= mem_arr[mem_raddr];
  end

  logic [11:0] wr_log[$];
  int          long_pulses = 0;
  logic        we_prev = 1'b0;
  always @(negedge clk) begin
    if (mem_we) begin
      wr_log.push_back({mem_waddr, mem_wdata});
      if (we_prev) long_pulses++;
    end
    we_prev = mem_we;
  end

  int checks = 0;
  int errors = 0;

  // Reference model: protocol applied to a whole frame at once.
  logic [7:0]  ref_mem [16];
  logic [7:0]  ref_ctrl;
  logic [11:0] exp_wr[$];
  logic [7:0]  exp_rd[$];
  logic [3:0]  exp_ra[$];
  logic [7:0]  got_rd[$];
  logic [3:0]  got_ra[$];
  logic        busy_mid;

  task automatic model_frame(input logic [7:0] fr[$]);
    int a;
    exp_wr.delete(); exp_rd.delete(); exp_ra.delete();
    if (fr.size() == 0) return;
    a = fr[0] % 16;
    case (fr[0] / 64)
      0: for (int i = 1; i < fr.size(); i++) begin
           exp_wr.push_back({a[3:0], fr[i]});
           ref_mem[a] = fr[i];
           a = (a + 1) % 16;
         end
      1: for (int i = 1; i < fr.size(); i++) begin
           exp_ra.push_back(a[3:0]);
           exp_rd.push_back(ref_mem[a]);
           a = (a + 1) % 16;
         end
      2: if (fr.size() > 1) ref_ctrl = fr[1];
      default: ;
    endcase
  endtask

  task automatic spi_xfer(input logic [7:0] tx, input int nbits,
                          output logic [7:0] rx, output logic [3:0] ra);
    rx = 8'h00;
    ra = 4'h0;
    for (int i = 7; i > 7 - nbits; i--) begin
      spi_mosi = tx[i];
      repeat (5) @(negedge clk);
      if (i == 7) ra = mem_raddr;
      rx[i] = spi_miso;
      spi_sclk = 1'b1;
      repeat (5) @(negedge clk);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic run_frame(input logic [7:0] fr[$]);
    logic [7:0] rx;
    logic [3:0] ra;
    wr_log.delete(); got_rd.delete(); got_ra.delete();
    spi_cs_n = 1'b0;
    repeat (6) @(negedge clk);
    busy_mid = busy;
    for (int i = 0; i < fr.size(); i++) begin
      spi_xfer(fr[i], 8, rx, ra);
      if (i > 0) begin
        got_rd.push_back(rx);
        got_ra.push_back(ra);
      end
    end
    repeat (4) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; spi_cs_n = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({mem_we, mem_waddr, mem_wdata, mem_raddr, ctrl_reg, busy, spi_miso} !== 27'd0) begin
      errors++;
      $display("FAIL reset_hold outputs=%h expected 0",
               {mem_we, mem_waddr, mem_wdata, mem_raddr, ctrl_reg, busy, spi_miso});
    end
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    checks++;
    if ({mem_we, mem_waddr, mem_wdata, mem_raddr, ctrl_reg, busy, spi_miso} !== 27'd0) begin
      errors++;
      $display("FAIL reset_release outputs=%h expected 0",
               {mem_we, mem_waddr, mem_wdata, mem_raddr, ctrl_reg, busy, spi_miso});
    end
  endtask

  task automatic test_write(input string nm, input logic [7:0] fr[$]);
    model_frame(fr);
    run_frame(fr);
    checks++;
    if (wr_log.size() !== exp_wr.size()) begin
      errors++;
      $display("FAIL %s write_count got=%0d exp=%0d", nm, wr_log.size(), exp_wr.size());
    end
    for (int i = 0; i < exp_wr.size() && i < wr_log.size(); i++) begin
      checks++;
      if (wr_log[i] !== exp_wr[i]) begin
        errors++;
        $display("FAIL %s write[%0d] addr/data got=%h exp=%h", nm, i, wr_log[i], exp_wr[i]);
      end
    end
    checks++;
    if (long_pulses !== 0) begin
      errors++;
      $display("FAIL %s we_pulse_width long_pulses=%0d exp=0", nm, long_pulses);
    end
    checks++;
    if (busy_mid !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy mid=%b after=%b exp 1/0", nm, busy_mid, busy);
    end
  endtask

  task automatic test_read(input logic [7:0] fr[$]);
    model_frame(fr);
    run_frame(fr);
    checks++;
    if (wr_log.size() !== 0) begin
      errors++;
      $display("FAIL read no_write got=%0d exp=0", wr_log.size());
    end
    for (int i = 0; i < exp_rd.size(); i++) begin
      checks++;
      if (got_rd[i] !== exp_rd[i] || got_ra[i] !== exp_ra[i]) begin
        errors++;
        $display("FAIL read byte[%0d] miso=%h raddr=%h exp miso=%h raddr=%h",
                 i, got_rd[i], got_ra[i], exp_rd[i], exp_ra[i]);
      end
    end
  endtask

  task automatic test_ctrl;
    logic [7:0] fr[$];
    fr = '{8'h80, 8'h5A, 8'hFF};
    model_frame(fr);
    run_frame(fr);
    checks++;
    if (ctrl_reg !== ref_ctrl || wr_log.size() !== 0) begin
      errors++;
      $display("FAIL ctrl_write ctrl=%h writes=%0d exp ctrl=%h writes=0", ctrl_reg, wr_log.size(), ref_ctrl);
    end
    fr = '{8'hC0, 8'h12};
    model_frame(fr);
    run_frame(fr);
    checks++;
    if (ctrl_reg !== ref_ctrl || wr_log.size() !== 0) begin
      errors++;
      $display("FAIL reserved_op ctrl=%h writes=%0d exp ctrl=%h writes=0", ctrl_reg, wr_log.size(), ref_ctrl);
    end
  endtask

  task automatic test_abort;
    logic [7:0] rx;
    logic [3:0] ra;
    wr_log.delete();
    spi_cs_n = 1'b0;
    repeat (6) @(negedge clk);
    spi_xfer(8'h03, 8, rx, ra);
    spi_xfer(8'h9C, 5, rx, ra);
    repeat (4) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (12) @(negedge clk);
    checks++;
    if (wr_log.size() !== 0) begin
      errors++;
      $display("FAIL abort_partial writes=%0d exp=0", wr_log.size());
    end
    test_write("after_abort", '{8'h03, 8'h77});
  endtask

  task automatic test_reset_mid;
    logic [7:0] rx;
    logic [3:0] ra;
    model_frame('{8'h00, 8'h33});
    wr_log.delete();
    spi_cs_n = 1'b0;
    repeat (6) @(negedge clk);
    spi_xfer(8'h00, 8, rx, ra);
    spi_xfer(8'h33, 8, rx, ra);
    spi_xfer(8'h44, 4, rx, ra);
    rst_n = 1'b0;
    ref_ctrl = 8'h00;
    @(negedge clk);
    checks++;
    if ({mem_we, mem_waddr, mem_wdata, mem_raddr, ctrl_reg, busy, spi_miso} !== 27'd0) begin
      errors++;
      $display("FAIL mid_reset outputs=%h expected 0",
               {mem_we, mem_waddr, mem_wdata, mem_raddr, ctrl_reg, busy, spi_miso});
    end
    @(negedge clk);
    rst_n = 1'b1;
    spi_xfer(8'h44, 4, rx, ra);
    spi_xfer(8'h55, 8, rx, ra);
    spi_xfer(8'h66, 8, rx, ra);
    repeat (4) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (12) @(negedge clk);
    checks++;
    if (wr_log.size() !== 1 || wr_log[0] !== exp_wr[0]) begin
      errors++;
      $display("FAIL mid_reset_ignore writes=%0d first=%h exp 1 write %h",
               wr_log.size(), wr_log[0], exp_wr[0]);
    end
    checks++;
    if (ctrl_reg !== ref_ctrl || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_ctrl ctrl=%h we=%b exp ctrl=%h we=0", ctrl_reg, mem_we, ref_ctrl);
    end
  endtask

  task automatic test_random;
    logic [7:0] fr[$];
    for (int n = 0; n < 14; n++) begin
      fr.delete();
      fr.push_back({2'($urandom_range(0, 3)), 2'b00, 4'($urandom_range(0, 15))});
      for (int k = 0; k < $urandom_range(0, 5); k++) fr.push_back(8'($urandom));
      model_frame(fr);
      run_frame(fr);
      checks++;
      if (wr_log.size() !== exp_wr.size() || ctrl_reg !== ref_ctrl) begin
        errors++;
        $display("FAIL rand[%0d] cmd=%h writes=%0d ctrl=%h exp writes=%0d ctrl=%h",
                 n, fr[0], wr_log.size(), ctrl_reg, exp_wr.size(), ref_ctrl);
      end
      for (int i = 0; i < exp_wr.size() && i < wr_log.size(); i++) begin
        checks++;
        if (wr_log[i] !== exp_wr[i]) begin
          errors++;
          $display("FAIL rand[%0d] write[%0d] got=%h exp=%h", n, i, wr_log[i], exp_wr[i]);
        end
      end
      for (int i = 0; i < exp_rd.size(); i++) begin
        checks++;
        if (got_rd[i] !== exp_rd[i] || got_ra[i] !== exp_ra[i]) begin
          errors++;
          $display("FAIL rand[%0d] read[%0d] miso=%h raddr=%h exp miso=%h raddr=%h",
                   n, i, got_rd[i], got_ra[i], exp_rd[i], exp_ra[i]);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem_arr[i] = 8'($urandom);
      ref_mem[i] = mem_arr[i];
    end
    ref_ctrl = 8'h00;
    test_reset();
    test_write("burst", '{8'h00, 8'hA1, 8'hB2, 8'hC3, 8'hD4});
    test_read('{8'h40, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)});
    test_write("wrap", '{8'h0F, 8'h11, 8'h22});
    test_ctrl();
    test_abort();
    test_reset_mid();
    test_write("recover", '{8'h05, 8'($urandom), 8'($urandom)});
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
